// File: rtl/axil_timer_regs.sv
// AXI4-Lite register window: ID, scratch, control, 64-bit cycle counter with coherent hi/lo snapshot.
// Define AXIL_TIMER_CMP_EN to add the CMP_LO/CMP_HI compare registers, CTRL.IRQ_EN and the irq output.
module axil_timer_regs #(
    parameter logic [31:0] ID_VALUE  = 32'h00FB_0001,
    parameter int          ADDR_BITS = 8,
    parameter int          CNT_W     = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        irq
);
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int IDX_W = ADDR_BITS - 2;
    localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_CNT_LO  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_SNAP_HI = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_CMP_LO  = IDX_W'(5);
    localparam logic [IDX_W-1:0] IDX_CMP_HI  = IDX_W'(6);

    function automatic logic idx_mapped(input logic [IDX_W-1:0] idx);
`ifdef AXIL_TIMER_CMP_EN
        return idx <= IDX_CMP_HI;
`else
        return idx <= IDX_SNAP_HI;
`endif
    endfunction

    w_state_t          w_state_reg, w_state_next;
    r_state_t          r_state_reg, r_state_next;
    logic              ready_en_reg;
    logic              aw_held_reg, w_held_reg;
    logic [IDX_W-1:0]  aw_idx_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic [1:0]        bresp_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;
    logic [31:0]       scratch_reg, scratch_next;
    logic              ctrl_en_reg;
    logic              ctrl_irq_en;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       snap_hi_reg;
    logic [31:0]       rd_value;
    logic              aw_hs, w_hs, ar_hs, wr_fire, clr;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              unused_addr_bits;

    // ready_en_reg keeps every ready low while reset is held and for the first cycle after
    assign awready = ready_en_reg && (w_state_reg == W_IDLE) && !aw_held_reg;
    assign wready  = ready_en_reg && (w_state_reg == W_IDLE) && !w_held_reg;
    assign arready = ready_en_reg && (r_state_reg == R_IDLE);
    assign bvalid  = (w_state_reg == W_RESP);
    assign rvalid  = (r_state_reg == R_DATA);
    assign bresp   = bresp_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign wr_fire = (w_state_reg == W_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    assign wr_idx  = aw_held_reg ? aw_idx_reg : awaddr[ADDR_BITS-1:2];
    assign wr_data = w_held_reg ? wdata_reg : wdata;
    assign wr_strb = w_held_reg ? wstrb_reg : wstrb;
    assign rd_idx  = araddr[ADDR_BITS-1:2];
    assign clr     = wr_fire && (wr_idx == IDX_CTRL) && wr_strb[0] && wr_data[1];
    assign unused_addr_bits = ^{awaddr[31:ADDR_BITS], awaddr[1:0], araddr[31:ADDR_BITS], araddr[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_scratch_lane
            assign scratch_next[gi*8 +: 8] = wr_strb[gi] ? wr_data[gi*8 +: 8] : scratch_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (wr_fire) w_state_next = W_RESP;
            W_RESP:  if (bready)  w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs)  r_state_next = R_DATA;
            R_DATA:  if (rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_reg <= 1'b0;
            w_state_reg  <= W_IDLE;
            r_state_reg  <= R_IDLE;
        end else begin
            ready_en_reg <= 1'b1;
            w_state_reg  <= w_state_next;
            r_state_reg  <= r_state_next;
        end
    end

    // AW and W are captured independently; the register update fires once both are present
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
        end else if (wr_fire) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bresp_reg   <= idx_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= awaddr[ADDR_BITS-1:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= wdata;
                wstrb_reg  <= wstrb;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            scratch_reg <= '0;
            ctrl_en_reg <= 1'b0;
        end else if (wr_fire) begin
            if (wr_idx == IDX_SCRATCH)
                scratch_reg <= scratch_next;
            if (wr_idx == IDX_CTRL && wr_strb[0])
                ctrl_en_reg <= wr_data[0];
        end
    end

    // Clear wins over increment; the write edge itself loads zero
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            cnt_reg <= '0;
        else if (clr)
            cnt_reg <= '0;
        else if (ctrl_en_reg)
            cnt_reg <= cnt_reg + CNT_W'(1);
    end

`ifdef AXIL_TIMER_CMP_EN
    logic        irq_en_reg, irq_reg;
    logic [31:0] cmp_lo_reg, cmp_hi_reg, cmp_lo_next, cmp_hi_next;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_cmp_lane
            assign cmp_lo_next[gi*8 +: 8] = wr_strb[gi] ? wr_data[gi*8 +: 8] : cmp_lo_reg[gi*8 +: 8];
            assign cmp_hi_next[gi*8 +: 8] = wr_strb[gi] ? wr_data[gi*8 +: 8] : cmp_hi_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_en_reg <= 1'b0;
            cmp_lo_reg <= 32'hFFFF_FFFF;
            cmp_hi_reg <= 32'hFFFF_FFFF;
            irq_reg    <= 1'b0;
        end else begin
            irq_reg <= irq_en_reg && (cnt_reg >= {cmp_hi_reg, cmp_lo_reg});
            if (wr_fire) begin
                if (wr_idx == IDX_CTRL && wr_strb[0])
                    irq_en_reg <= wr_data[2];
                if (wr_idx == IDX_CMP_LO)
                    cmp_lo_reg <= cmp_lo_next;
                if (wr_idx == IDX_CMP_HI)
                    cmp_hi_reg <= cmp_hi_next;
            end
        end
    end

    assign ctrl_irq_en = irq_en_reg;
    assign irq         = irq_reg;
`else
    assign ctrl_irq_en = 1'b0;
    assign irq         = 1'b0;
`endif

    always_comb begin
        rd_value = '0;
        case (rd_idx)
            IDX_ID:      rd_value = ID_VALUE;
            IDX_SCRATCH: rd_value = scratch_reg;
            IDX_CTRL:    rd_value = {29'd0, ctrl_irq_en, 1'b0, ctrl_en_reg};
            IDX_CNT_LO:  rd_value = cnt_reg[31:0];
            IDX_SNAP_HI: rd_value = snap_hi_reg;
`ifdef AXIL_TIMER_CMP_EN
            IDX_CMP_LO:  rd_value = cmp_lo_reg;
            IDX_CMP_HI:  rd_value = cmp_hi_reg;
`endif
            default:     rd_value = '0;
        endcase
    end

    // The high word is snapshotted on the same edge the low word is sampled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
            snap_hi_reg <= '0;
        end else if (ar_hs) begin
            rdata_reg <= rd_value;
            rresp_reg <= idx_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
            if (rd_idx == IDX_CNT_LO)
                snap_hi_reg <= cnt_reg[63:32];
        end
    end
endmodule

// File: tb/tb_axil_timer_regs.sv
// Scoreboard bench for axil_timer_regs: directed AXI-Lite transactions, responses checked by a monitor.
module tb_axil_timer_regs;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, irq;
    logic [1:0]  bresp, rresp;

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  resp;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    axil_timer_regs dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .irq(irq)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timeout", name);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Monitor: one comparison per completed R or B handshake
    always @(negedge aclk) begin
        if (aresetn && rvalid && rready) begin
            exp_t e;
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_r: rdata %h rresp %0d with no read pending", rdata, rresp);
            end else begin
                e = rd_q.pop_front();
                if (rdata < e.lo || rdata > e.hi || rresp !== e.resp) begin
                    errors++;
                    $display("FAIL %s: rdata %h rresp %0d, required [%h..%h] rresp %0d",
                             e.name, rdata, rresp, e.lo, e.hi, e.resp);
                end else
                    $display("read  %-14s rdata %h rresp %0d", e.name, rdata, rresp);
            end
        end
        if (aresetn && bvalid && bready) begin
            exp_t e;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_b: bresp %0d with no write pending", bresp);
            end else begin
                e = wr_q.pop_front();
                if (bresp !== e.resp) begin
                    errors++;
                    $display("FAIL %s: bresp %0d, required %0d", e.name, bresp, e.resp);
                end else
                    $display("write %-14s bresp %0d", e.name, bresp);
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input logic [1:0] resp, input string name);
        exp_t e;
        int   n;
        e.name = name; e.lo = '0; e.hi = '0; e.resp = resp;
        wr_q.push_back(e);
        fork
            begin
                int k = 0;
                repeat (aw_dly) begin @(posedge aclk); #1; end
                awaddr = addr; awvalid = 1'b1;
                @(negedge aclk);
                while (!awready && k < 100) begin @(negedge aclk); k++; end
                if (k >= 100) timeout({name, "_aw"});
                @(posedge aclk); #1;
                awvalid = 1'b0;
            end
            begin
                int k = 0;
                repeat (w_dly) begin @(posedge aclk); #1; end
                wdata = data; wstrb = strb; wvalid = 1'b1;
                @(negedge aclk);
                while (!wready && k < 100) begin @(negedge aclk); k++; end
                if (k >= 100) timeout({name, "_w"});
                @(posedge aclk); #1;
                wvalid = 1'b0;
            end
        join
        n = 0;
        @(negedge aclk);
        while (!bvalid && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) timeout({name, "_b"});
        @(posedge aclk); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] lo, input logic [31:0] hi,
                            input logic [1:0] resp, input string name, input int hold);
        exp_t        e;
        int          n;
        logic [31:0] first;
        e.name = name; e.lo = lo; e.hi = hi; e.resp = resp;
        rd_q.push_back(e);
        rready = (hold == 0);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!arready && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) timeout({name, "_ar"});
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!rvalid && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) timeout({name, "_r"});
        if (hold > 0) begin
            first = rdata;
            for (int k = 0; k < hold; k++) begin
                @(negedge aclk);
                chk("hold_rvalid", 32'(rvalid), 32'd1);
                chk("hold_rdata", rdata, first);
                chk("hold_arready", 32'(arready), 32'd0);
            end
            @(posedge aclk); #1;
            rready = 1'b1;
            @(negedge aclk);
        end
        @(posedge aclk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        cycles(3);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        chk("rst_resp",    32'({bresp, rresp}), 32'd0);
        chk("rst_irq",     32'(irq),     32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        cycles(1);

        axi_read(32'h00, 32'h00FB_0001, 32'h00FB_0001, OKAY, "id", 0);
        axi_read(32'h04, 32'h0, 32'h0, OKAY, "scratch_rst", 0);
        axi_read(32'h08, 32'h0, 32'h0, OKAY, "ctrl_rst", 0);
        axi_read(32'h0C, 32'h0, 32'h0, OKAY, "cnt_lo_rst", 0);
        axi_read(32'h10, 32'h0, 32'h0, OKAY, "snap_hi_rst", 0);

        // W three cycles ahead of AW, low two bytes only
        axi_write(32'h04, 32'hA5A5_A5A5, 4'b0011, 3, 0, OKAY, "scratch_w_first");
        axi_read(32'h04, 32'h0000_A5A5, 32'h0000_A5A5, OKAY, "scratch_lo", 0);
        axi_write(32'h04, 32'h1234_5678, 4'b1100, 0, 2, OKAY, "scratch_aw_first");
        axi_read(32'h04, 32'h1234_A5A5, 32'h1234_A5A5, OKAY, "scratch_hi", 0);
        axi_read(32'h104, 32'h1234_A5A5, 32'h1234_A5A5, OKAY, "scratch_alias", 0);
        axi_write(32'h00, 32'hDEAD_BEEF, 4'b1111, 0, 0, OKAY, "id_ro_write");
        axi_read(32'h00, 32'h00FB_0001, 32'h00FB_0001, OKAY, "id_after_wr", 0);

        axi_read(32'h20, 32'h0, 32'h0, SLVERR, "unmapped_rd", 0);
        axi_write(32'h24, 32'hFFFF_FFFF, 4'b1111, 0, 0, SLVERR, "unmapped_wr");
        axi_read(32'h04, 32'h1234_A5A5, 32'h1234_A5A5, OKAY, "scratch_kept", 0);
`ifndef AXIL_TIMER_CMP_EN
        axi_read(32'h14, 32'h0, 32'h0, SLVERR, "cmp_lo_absent", 0);
        axi_write(32'h18, 32'h0, 4'b1111, 0, 0, SLVERR, "cmp_hi_absent");
`endif

        // Counter runs 100 cycles from reset value
        axi_write(32'h08, 32'h1, 4'b0001, 0, 0, OKAY, "ctrl_en");
        cycles(100);
        axi_read(32'h0C, 32'd100, 32'd110, OKAY, "cnt_lo_100", 0);
        axi_read(32'h10, 32'h0, 32'h0, OKAY, "snap_hi_100", 0);
        axi_read(32'h08, 32'h1, 32'h1, OKAY, "ctrl_rd_en", 0);

        // CLR with EN=0: counter zero and stopped
        axi_write(32'h08, 32'h2, 4'b0001, 0, 0, OKAY, "ctrl_clr_stop");
        axi_read(32'h0C, 32'h0, 32'h0, OKAY, "cnt_lo_clr", 0);
        cycles(5);
        axi_read(32'h0C, 32'h0, 32'h0, OKAY, "cnt_lo_stopped", 0);
        axi_read(32'h10, 32'h0, 32'h0, OKAY, "snap_hi_clr", 0);

        // 32-bit carry: LO sampled before the carry, HI read after must still be the snapshot
        force dut.cnt_reg = 64'h0000_0000_FFFF_FFF0;
        cycles(1);
        release dut.cnt_reg;
        cycles(1);
        axi_write(32'h08, 32'h1, 4'b0001, 0, 0, OKAY, "ctrl_en_carry");
        axi_read(32'h0C, 32'hFFFF_FFF0, 32'hFFFF_FFFF, OKAY, "cnt_lo_precarry", 0);
        cycles(30);
        axi_read(32'h10, 32'h0, 32'h0, OKAY, "snap_hi_coherent", 0);
        axi_read(32'h0C, 32'h8, 32'h30, OKAY, "cnt_lo_postcarry", 0);
        axi_read(32'h10, 32'h1, 32'h1, OKAY, "snap_hi_carried", 0);

        // Full 64-bit wrap
        axi_write(32'h08, 32'h0, 4'b0001, 0, 0, OKAY, "ctrl_stop");
        force dut.cnt_reg = 64'hFFFF_FFFF_FFFF_FFF0;
        cycles(1);
        release dut.cnt_reg;
        cycles(1);
        axi_write(32'h08, 32'h1, 4'b0001, 0, 0, OKAY, "ctrl_en_wrap");
        cycles(30);
        axi_read(32'h0C, 32'h8, 32'h30, OKAY, "cnt_lo_wrap", 0);
        axi_read(32'h10, 32'h0, 32'h0, OKAY, "snap_hi_wrap", 0);

        // EN+CLR together, then hold R for 5 cycles while the counter keeps running
        axi_write(32'h08, 32'h3, 4'b0001, 0, 0, OKAY, "ctrl_en_clr");
        axi_read(32'h0C, 32'h0, 32'h3, OKAY, "cnt_lo_hold", 5);
        axi_read(32'h08, 32'h1, 32'h1, OKAY, "ctrl_clr_rd0", 0);

        // Same-cycle CNT_LO read and CLR write returns the pre-clear value
        axi_write(32'h08, 32'h0, 4'b0001, 0, 0, OKAY, "ctrl_stop2");
        force dut.cnt_reg = 64'h0000_0000_0000_1234;
        cycles(1);
        release dut.cnt_reg;
        cycles(1);
        fork
            axi_write(32'h08, 32'h2, 4'b0001, 0, 0, OKAY, "clr_same_cycle");
            axi_read(32'h0C, 32'h1234, 32'h1234, OKAY, "cnt_lo_preclr", 0);
        join
        axi_read(32'h0C, 32'h0, 32'h0, OKAY, "cnt_lo_postclr", 0);

`ifdef AXIL_TIMER_CMP_EN
        axi_read(32'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OKAY, "cmp_lo_rst", 0);
        axi_read(32'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OKAY, "cmp_hi_rst", 0);
        axi_write(32'h14, 32'd50, 4'b1111, 0, 0, OKAY, "cmp_lo_wr");
        axi_write(32'h18, 32'd0, 4'b1111, 0, 0, OKAY, "cmp_hi_wr");
        axi_read(32'h14, 32'd50, 32'd50, OKAY, "cmp_lo_rd", 0);
        axi_write(32'h08, 32'h5, 4'b0001, 0, 0, OKAY, "ctrl_en_irq");
        n = 0;
        do begin @(negedge aclk); n++; end while (!irq && n < 200);
        chk("irq_rise_cycle", 32'(n), 32'd51);
        @(posedge aclk); #1;
        axi_write(32'h08, 32'h6, 4'b0001, 0, 0, OKAY, "ctrl_clr_irq");
        chk("irq_fall", 32'(irq), 32'd0);
        axi_read(32'h08, 32'h4, 32'h4, OKAY, "ctrl_irq_en_rd", 0);
`else
        axi_write(32'h08, 32'h7, 4'b0001, 0, 0, OKAY, "ctrl_all_bits");
        axi_read(32'h08, 32'h1, 32'h1, OKAY, "ctrl_bit2_absent", 0);
        cycles(20);
        chk("irq_tied_low", 32'(irq), 32'd0);
`endif

        // Reset dropped right after a write is accepted: no B response, state back to reset
        awaddr = 32'h04; awvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_bvalid", 32'(bvalid), 32'd0);
        chk("midrst_awready", 32'(awready), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        cycles(2);
        @(negedge aclk);
        aresetn = 1'b1;
        cycles(1);
        axi_read(32'h04, 32'h0, 32'h0, OKAY, "scratch_midrst", 0);
        axi_read(32'h08, 32'h0, 32'h0, OKAY, "ctrl_midrst", 0);
        axi_read(32'h0C, 32'h0, 32'h0, OKAY, "cnt_lo_midrst", 0);

        cycles(2);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
